fb_scanout: RTL and testbench

- Receiving end of the pixel-plot interface used by the sprite and animation drawers: accepts (x, y, colour, plot) writes into an internal 320x240x3 framebuffer.
- Continuously rasters the framebuffer to the VGA DAC at 640x480@60 Hz, doubling each stored pixel 2x2.
- Sits between the draw datapath/control FSMs and the board VGA pins.
- Lightweight replacement for the vendor adapter, with a status/debug port.

---
 rtl/fb_scanout.sv | 185 ++++++++++++++++++
 tb/tb_fb_scanout.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: 320x240x3 framebuffer with a pixel-plot write port and a
// 640x480@60 Hz VGA raster that shows every stored pixel as a 2x2 block.
//
// Ports
//   CLOCK_50     in   50 MHz system clock
//   reset        in   synchronous, active-low
//   x, y         in   write column (0..319) / row (0..239)
//   colour       in   {R,G,B} write data
//   plot         in   write strobe, one write per cycle, no backpressure
//   wr_drop_cnt  out  saturating count of plots rejected as out of range
//   frame_start  out  one-cycle pulse at the start of each output frame
//   VGA_CLK      out  25 MHz pixel clock
//   VGA_HS/VS    out  active-low syncs
//   VGA_BLANK_N  out  high in the visible region
//   VGA_SYNC_N   out  tied low
//   VGA_R/G/B    out  10-bit channels, each driven from one colour bit
module fb_scanout #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic [15:0] wr_drop_cnt,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B
);

    localparam int FB_DEPTH = H_RES * V_RES;

    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_BEGIN = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [8:0] X_LIMIT  = 9'(H_RES);
    localparam logic [7:0] Y_LIMIT  = 8'(V_RES);

    // ------------------------------------------------------------------
    // Pixel enable and raster counters
    // ------------------------------------------------------------------
    logic       pix_en;
    logic [9:0] hcnt;
    logic [9:0] vcnt;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pix_en      <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            VGA_CLK     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            VGA_CLK     <= pix_en;
            // Pulse lands on the edge where the raster leaves (0,0) for the
            // first time, i.e. the cycle after pix_en=1 at the origin.
            frame_start <= pix_en && (hcnt == '0) && (vcnt == '0);
            if (pix_en) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    if (vcnt == V_LAST) begin
                        vcnt <= '0;
                    end else begin
                        vcnt <= vcnt + 10'd1;
                    end
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    logic visible;
    logic hsync_raw;
    logic vsync_raw;

    assign visible   = (hcnt < H_VIS_L) && (vcnt < V_VIS_L);
    assign hsync_raw = !((hcnt >= HS_BEGIN) && (hcnt < HS_END));
    assign vsync_raw = !((vcnt >= VS_BEGIN) && (vcnt < VS_END));

    // ------------------------------------------------------------------
    // Write port: address = y*320 + x built from shifts
    // ------------------------------------------------------------------
    logic        wr_in_range;
    logic        wr_en;
    logic [16:0] wr_addr;

    assign wr_in_range = (x < X_LIMIT) && (y < Y_LIMIT);
    assign wr_en       = plot && wr_in_range;
    assign wr_addr     = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            wr_drop_cnt <= '0;
        end else if (plot && !wr_in_range && (wr_drop_cnt != '1)) begin
            wr_drop_cnt <= wr_drop_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read address: each stored pixel covers a 2x2 block of output pixels.
    // vcnt[9] is always zero inside the visible region, so rows fit 8 bits.
    // ------------------------------------------------------------------
    logic [7:0]  rd_row;
    logic [8:0]  rd_col;
    logic [16:0] rd_addr;

    assign rd_row  = vcnt[8:1];
    assign rd_col  = hcnt[9:1];
    assign rd_addr = {1'b0, rd_row, 8'b0} + {3'b0, rd_row, 6'b0} + {8'b0, rd_col};

    // ------------------------------------------------------------------
    // Framebuffer: simple dual-port, read-before-write on a same-address
    // collision so the scanout sees the old pixel this frame. Not reset.
    // ------------------------------------------------------------------
    logic [2:0] fb_mem [FB_DEPTH];
    logic [2:0] rd_data;

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= colour;
        end
        if (visible) begin
            rd_data <= fb_mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: stage 1 matches the RAM read latency, stage 2 is the
    // pin register, so sync, blank and colour leave together two cycles
    // after the counter value that produced them.
    // ------------------------------------------------------------------
    logic hs_d1;
    logic vs_d1;
    logic vis_d1;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            hs_d1       <= 1'b1;
            vs_d1       <= 1'b1;
            vis_d1      <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            hs_d1       <= hsync_raw;
            vs_d1       <= vsync_raw;
            vis_d1      <= visible;
            VGA_HS      <= hs_d1;
            VGA_VS      <= vs_d1;
            VGA_BLANK_N <= vis_d1;
            VGA_R       <= (vis_d1 && rd_data[2]) ? '1 : '0;
            VGA_G       <= (vis_d1 && rd_data[1]) ? '1 : '0;
            VGA_B       <= (vis_d1 && rd_data[0]) ? '1 : '0;
        end
    end

    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized bench for fb_scanout against a cycle-count based
// reference model. The raster timing is shrunk (64x24 visible output pixels)
// so several frames fit in a short run; the stored frame keeps its full
// 320x240 size, so the visible window covers stored pixels x<32, y<12.
module tb_fb_scanout;

    localparam int H_VIS  = 64;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 8;
    localparam int H_BP   = 4;
    localparam int V_VIS  = 24;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 2;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int WIN_W  = H_VIS / 2;
    localparam int WIN_H  = V_VIS / 2;
    localparam int MID_POS = 15 * H_TOT + 40;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic [15:0] wr_drop_cnt;
    logic        frame_start;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic [9:0]  VGA_R;
    logic [9:0]  VGA_G;
    logic [9:0]  VGA_B;

    fb_scanout #(
        .H_RES (320),
        .V_RES (240),
        .H_VIS (H_VIS),
        .H_FP  (H_FP),
        .H_SYNC(H_SYNC),
        .H_BP  (H_BP),
        .V_VIS (V_VIS),
        .V_FP  (V_FP),
        .V_SYNC(V_SYNC),
        .V_BP  (V_BP)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .wr_drop_cnt(wr_drop_cnt),
        .frame_start(frame_start),
        .VGA_CLK    (VGA_CLK),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model state. k counts CLOCK_50 edges since reset release (0 in reset).
    int          k;
    int unsigned ref_drop;
    logic [3:0]  ref_mem [76800];   // bit 3 = contents known
    logic [3:0]  pred [2];          // colour read for the pins two edges later
    int          hs_fall;
    int          vs_fall;
    int          fs_last;
    logic        hs_prev;
    logic        vs_prev;
    logic        arm_tl;
    logic        arm_row10;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [29:0] expand(input logic [2:0] c);
        return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    // Stored pixel shown for the raster position reached after edge j.
    function automatic logic [3:0] predict(input int j);
        int p;
        int h;
        int v;
        p = (j / 2) % FRAME;
        h = p % H_TOT;
        v = p / H_TOT;
        if (h < H_VIS && v < V_VIS) begin
            return ref_mem[17'((v / 2) * 320 + h / 2)];
        end
        return 4'b1000;
    endfunction

    // One clock edge: update the model with the inputs that edge saw, then
    // compare every output against the model.
    task automatic step();
        int         p;
        int         h;
        int         v;
        logic       vis;
        logic       e_clk;
        logic       e_hs;
        logic       e_vs;
        logic       e_fs;
        logic [3:0] c;
        @(posedge CLOCK_50);
        #1;
        if (!reset) begin
            k        = 0;
            ref_drop = 0;
            hs_fall  = -1;
            vs_fall  = -1;
            fs_last  = -1;
            hs_prev  = 1'b1;
            vs_prev  = 1'b1;
        end else begin
            k++;
            if (plot) begin
                if (x < 9'd320 && y < 8'd240) begin
                    ref_mem[17'(int'(y) * 320 + int'(x))] = {1'b1, colour};
                end else if (ref_drop < 65535) begin
                    ref_drop++;
                end
            end
        end
        check("drop_cnt", 64'(wr_drop_cnt), 64'(ref_drop));
        if (k < 2) begin
            check("sync_reset", 64'({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start}),
                  64'(6'b011000));
            check("rgb_reset", 64'({VGA_R, VGA_G, VGA_B}), 64'(0));
        end else begin
            p     = ((k - 2) / 2) % FRAME;
            h     = p % H_TOT;
            v     = p / H_TOT;
            vis   = (h < H_VIS) && (v < V_VIS);
            e_clk = (k % 2) == 0;
            e_hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
            e_vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
            e_fs  = ((k - 2) % (2 * FRAME)) == 0;
            check("sync", 64'({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start}),
                  64'({e_clk, e_hs, e_vs, vis, 1'b0, e_fs}));
            c = pred[k % 2];
            if (c[3]) begin
                check("rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(expand(c[2:0])));
            end
            if (arm_tl && h < 2 && v < 2) begin
                check("px_top_left", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'h3FF, 20'h0}));
            end
            if (arm_row10 && vis && (v == 20 || v == 21)) begin
                check("row10_white", 64'({VGA_R, VGA_G, VGA_B}), 64'({30{1'b1}}));
            end
            if (hs_prev && !VGA_HS) begin
                if (hs_fall < 0) check("hs_first_fall", 64'(k), 64'(2 * (H_VIS + H_FP) + 2));
                else             check("hs_period", 64'(k - hs_fall), 64'(2 * H_TOT));
                hs_fall = k;
            end
            if (!hs_prev && VGA_HS && hs_fall >= 0) begin
                check("hs_low", 64'(k - hs_fall), 64'(2 * H_SYNC));
            end
            if (vs_prev && !VGA_VS) begin
                if (vs_fall < 0) check("vs_first_fall", 64'(k), 64'(2 * (V_VIS + V_FP) * H_TOT + 2));
                else             check("vs_period", 64'(k - vs_fall), 64'(2 * FRAME));
                vs_fall = k;
            end
            if (!vs_prev && VGA_VS && vs_fall >= 0) begin
                check("vs_low", 64'(k - vs_fall), 64'(2 * H_TOT * V_SYNC));
            end
            if (frame_start) begin
                if (fs_last < 0) check("fs_first", 64'(k), 64'(2));
                else             check("fs_period", 64'(k - fs_last), 64'(2 * FRAME));
                fs_last = k;
            end
            hs_prev = VGA_HS;
            vs_prev = VGA_VS;
        end
        pred[k % 2] = predict(k);
    endtask

    task automatic bad_plot();
        plot = 1'b1;
        if ($urandom % 2 == 0) begin
            x = 9'($urandom_range(320, 511));
            y = 8'($urandom % 256);
        end else begin
            x = 9'($urandom % 320);
            y = 8'($urandom_range(240, 255));
        end
        colour = 3'($urandom);
    endtask

    // Background traffic that never touches the visible window.
    task automatic idle();
        int unsigned r;
        r = $urandom % 8;
        if (r == 0) begin
            plot = 1'b0;
        end else if (r == 1) begin
            plot   = 1'b1;
            x      = 9'($urandom_range(WIN_W, 319));
            y      = 8'($urandom_range(0, 239));
            colour = 3'($urandom);
        end else begin
            bad_plot();
        end
    endtask

    task automatic wr(input int xx, input int yy, input logic [2:0] c);
        plot   = 1'b1;
        x      = 9'(xx);
        y      = 8'(yy);
        colour = c;
        step();
    endtask

    // Write the pixel the scanout reads on the very next edge.
    task automatic collide();
        int p;
        int h;
        int v;
        p = (k / 2) % FRAME;
        h = p % H_TOT;
        v = p / H_TOT;
        if (h < H_VIS && v < V_VIS) begin
            plot   = 1'b1;
            x      = 9'(h / 2);
            y      = 8'(v / 2);
            colour = 3'($urandom);
        end else begin
            idle();
        end
        step();
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        plot      = 1'b0;
        x         = '0;
        y         = '0;
        colour    = '0;
        k         = 0;
        ref_drop  = 0;
        arm_tl    = 1'b0;
        arm_row10 = 1'b0;
        hs_fall   = -1;
        vs_fall   = -1;
        fs_last   = -1;
        hs_prev   = 1'b1;
        vs_prev   = 1'b1;
        pred[0]   = 4'b0000;
        pred[1]   = 4'b0000;
        for (int unsigned i = 0; i < 76800; i++) ref_mem[i] = 4'b0000;

        repeat (5) step();
        reset = 1'b1;

        wr(320, 0, 3'b101);
        wr(0, 240, 3'b010);
        wr(511, 255, 3'b111);
        check("drop_three", 64'(wr_drop_cnt), 64'(3));

        // Run to the mid-frame point, then pulse reset for one edge there.
        n = 0;
        while (((k / 2) % FRAME) != MID_POS && n < 2 * FRAME + 10) begin
            idle();
            step();
            n++;
        end
        check("mid_frame_reached", 64'(n < 2 * FRAME + 10), 64'(1));
        plot  = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;

        for (int unsigned yy = 0; yy < WIN_H; yy++) begin
            for (int unsigned xx = 0; xx < WIN_W; xx++) begin
                wr(int'(xx), int'(yy), 3'($urandom));
            end
        end
        wr(0, 0, 3'b100);
        wr(319, 239, 3'b011);
        for (int unsigned xx = 0; xx < 320; xx++) wr(int'(xx), 10, 3'b111);
        check("drop_after_good_writes", 64'(wr_drop_cnt), 64'(0));

        plot = 1'b0;
        step();
        arm_tl    = 1'b1;
        arm_row10 = 1'b1;
        repeat (2 * FRAME + 200) begin
            idle();
            step();
        end
        arm_tl    = 1'b0;
        arm_row10 = 1'b0;

        repeat (1500) collide();
        repeat (2 * FRAME + 200) begin
            idle();
            step();
        end

        n = 0;
        while (ref_drop < 65535 && n < 70000) begin
            bad_plot();
            step();
            n++;
        end
        check("drop_saturated", 64'(wr_drop_cnt), 64'(16'hFFFF));
        bad_plot();
        step();
        check("drop_held", 64'(wr_drop_cnt), 64'(16'hFFFF));
        plot = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
